// File: rtl/store_write_buffer.sv
// Posted-store FIFO between the MEM stage and a slower data memory port, with
// youngest-match load forwarding. Define STORE_COALESCE_EN to merge same-address stores.
module store_write_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       st_valid,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [DATA_W-1:0]          st_data,
  output logic                       st_ready,
  output logic                       stall_out,
  input  logic                       ld_valid,
  input  logic [ADDR_W-1:0]          ld_addr,
  output logic                       ld_hit,
  output logic [DATA_W-1:0]          ld_data,
  output logic                       mem_req_valid,
  output logic [ADDR_W-1:0]          mem_req_addr,
  output logic [DATA_W-1:0]          mem_req_data,
  input  logic                       mem_req_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  logic              full;
  logic              alloc;
  logic              deq;
  logic              fwd_match;
  logic [PTR_W-1:0]  fwd_idx;

`ifdef STORE_COALESCE_EN
  logic [PTR_W-1:0]  youngest;
  logic              coalesce;

  // Youngest entry is only mergeable when it is not the head on the memory port.
  assign youngest = tail_q - PTR_W'(1);
  assign coalesce = st_valid && (count_q >= CNT_W'(2)) && (addr_q[youngest] == st_addr);
`endif

  assign full          = (count_q == CNT_W'(DEPTH));
  assign empty         = (count_q == '0);
  assign count         = count_q;
  assign mem_req_valid = !empty;
  assign mem_req_addr  = addr_q[head_q];
  assign mem_req_data  = data_q[head_q];
  assign deq           = mem_req_valid && mem_req_ready;

  always_comb begin
`ifdef STORE_COALESCE_EN
    st_ready = !full || coalesce;
    alloc    = st_valid && !full && !coalesce;
`else
    st_ready = !full;
    alloc    = st_valid && !full;
`endif
    stall_out = st_valid && !st_ready;

    addr_d = addr_q;
    data_d = data_q;
    head_d = head_q;
    tail_d = tail_q;

    if (alloc) begin
      addr_d[tail_q] = st_addr;
      data_d[tail_q] = st_data;
      tail_d         = tail_q + PTR_W'(1);
    end
`ifdef STORE_COALESCE_EN
    if (coalesce) begin
      data_d[youngest] = st_data;
    end
`endif
    if (deq) begin
      head_d = head_q + PTR_W'(1);
    end

    unique case ({alloc, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Walk oldest to youngest so the last hit left standing is the youngest match.
  always_comb begin
    fwd_match = 1'b0;
    fwd_idx   = '0;
    ld_data   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_q[fwd_idx] == ld_addr)) begin
        fwd_match = 1'b1;
        ld_data   = data_q[fwd_idx];
      end
    end
    ld_hit = ld_valid && fwd_match;
    if (!ld_hit) begin
      ld_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Posted-store FIFO directly downstream of the pipeline's MEM stage, between the EX/MEM store path and a slower data memory port.
- Captures MemWrite requests (address, data) in one cycle so the pipeline does not wait for memory.
- Drains entries in order over a valid/ready handshake.
- Forwards the youngest buffered store data to MEM-stage loads on an address match, preserving read-after-write ordering.

Parameters:
DEPTH, 4, number of entries; power of two, minimum 2
ADDR_W, 64, address width
DATA_W, 64, store data width

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
st_valid  input  1  store request from MEM stage (EX/MEM MemWrite)
st_addr  input  ADDR_W  store address (EX/MEM ALU result)
st_data  input  DATA_W  store data (EX/MEM forwarded rs2)
st_ready  output  1  buffer can accept a store this cycle
stall_out  output  1  st_valid && !st_ready; pipeline must freeze PC, IF/ID, ID/EX, EX/MEM
ld_valid  input  1  MEM-stage load (EX/MEM MemRead)
ld_addr  input  ADDR_W  load address
ld_hit  output  1  a buffered store matches ld_addr
ld_data  output  DATA_W  data of youngest matching entry; 0 when !ld_hit
mem_req_valid  output  1  head entry presented to memory
mem_req_addr  output  ADDR_W  head address
mem_req_data  output  DATA_W  head data
mem_req_ready  input  1  memory accepts head this cycle
count  output  $clog2(DEPTH+1)  occupied entries
empty  output  1  count == 0

Behaviour:
- Storage: circular array of DEPTH {addr, data}; head (oldest) and tail (next free) pointers; both wrap modulo DEPTH.
- Reset (sync, active-high): head=0, tail=0, count=0. Outputs: mem_req_valid=0, ld_hit=0, ld_data=0, st_ready=1, stall_out=0, empty=1. Pending entries are discarded, including reset during a stalled handshake. Array contents are don't-care.
- st_ready = (count != DEPTH). Combinational from registered count only; does not depend on same-cycle mem_req_ready.
- Enqueue when st_valid && st_ready:
  - Write entry[tail]; tail+1.
  - Visible to drain and forwarding from the next cycle.
  - Latency: store presented at cycle N appears on mem_req_* at N+1 at the earliest.
- Dequeue when mem_req_valid && mem_req_ready: head+1.
- mem_req_valid = !empty. mem_req_addr/mem_req_data = entry[head], held stable while valid && !ready.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Full with dequeue in the same cycle: the store is still refused (st_ready=0), stall_out=1, accepted next cycle.
- Empty: mem_req_valid=0, and the address/data outputs are don't-care.
- Forwarding (combinational):
  - Compare ld_addr against all occupied entries (exact full-width match).
  - ld_hit = ld_valid && any match. ld_data = data of the youngest match (closest to tail).
  - The head entry being dequeued this cycle still forwards.
  - The same-cycle incoming st_* is not searched.
- On ld_hit, memory read data is overridden by ld_data in the MEM/WB path (outside this block).
- count is a registered value; empty = (count==0).

Optional Feature:
STORE_COALESCE_EN
- Defined: an incoming store whose st_addr equals the youngest entry's address, with count >= 2 (so that entry is not the head being presented), overwrites that entry's data in place.
  - tail and count do not change.
  - Such a store is accepted even when full: st_ready = !full || coalesce_match.
- Undefined: every accepted store allocates a new entry. No coalescing logic is present.

Test Plan:
- Reset, then st_valid with addr=0x10, data=0xAA, mem_req_ready=0 -> next cycle count=1, mem_req_valid=1, mem_req_addr=0x10, mem_req_data=0xAA; values stay stable for 5 cycles; ready=1 for one cycle -> count=0, empty=1.
- Four stores to 0x0/0x8/0x10/0x18 with ready=0, then a fifth store -> st_ready=0, stall_out=1, count=4. Raise ready -> drain order 0x0, 0x8, 0x10, 0x18. Fifth store accepted the cycle after the first dequeue.
- Stores 0x20=0x1 then 0x20=0x2, then ld_valid, ld_addr=0x20 -> ld_hit=1, ld_data=0x2. ld_addr=0x28 -> ld_hit=0, ld_data=0.
- Full buffer with ready=1 held continuously and st_valid every cycle -> one entry accepted per cycle after the first refusal, and pointers wrap past DEPTH-1 with no loss (check 12 stores drain in order).
- Reset asserted with 3 pending entries and ready=0 -> next cycle count=0, mem_req_valid=0, ld_hit=0 for a previously buffered address.
- STORE_COALESCE_EN: stores 0x0=1, 0x8=2, 0x8=3 -> count=2; drain yields 0x0=1, 0x8=3. Without the macro: count=3, drain yields 0x0=1, 0x8=2, 0x8=3.
